// File: rtl/pool_pkg.sv
// Shared types and defaults for the pooling layer and its output stream stage.
package pool_pkg;

  localparam int POOL_ELEM_WIDTH     = 8;
  localparam int POOL_MAX_OUT_HEIGHT = 32;
  localparam int POOL_MAX_OUT_WIDTH  = 32;

  typedef enum logic [1:0] {
    POOL_MAX = 2'd0,
    POOL_AVG = 2'd1,
    POOL_MIN = 2'd2
  } pool_mode_e;

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic [7:0] height;
    logic [7:0] width;
  } frame_dims_t;

  function automatic logic dims_legal(input frame_dims_t d, input int max_h, input int max_w);
    return (d.height != 8'd0) && (int'(d.height) <= max_h) &&
           (d.width  != 8'd0) && (int'(d.width)  <= max_w);
  endfunction

endpackage

// File: rtl/pool_out_serializer_cnt.sv
// Row/column position counter for a row-major stream; exposes the position after the next step
// so the owner can register its per-beat outputs one cycle ahead.
module stream_counter_2d (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] height,
  input  logic [7:0] width,
  output logic [7:0] nxt_row,
  output logic [7:0] nxt_col,
  output logic       nxt_last_col,
  output logic       nxt_last
);

  logic [7:0] row;
  logic [7:0] col;
  logic       col_wrap;

  assign col_wrap     = (col == width - 8'd1);
  assign nxt_col      = col_wrap ? 8'd0 : col + 8'd1;
  assign nxt_row      = col_wrap ? row + 8'd1 : row;
  assign nxt_last_col = (nxt_col == width - 8'd1);
  assign nxt_last     = nxt_last_col && (nxt_row == height - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 8'd0;
      col <= 8'd0;
    end else if (load) begin
      row <= 8'd0;
      col <= 8'd0;
    end else if (step) begin
      row <= nxt_row;
      col <= nxt_col;
    end
  end

endmodule

// File: rtl/pool_out_serializer.sv
// Latches a pooled frame on its valid pulse and streams it one element per beat, row-major,
// with end-of-row / end-of-frame marks; all outputs are registered, none depend on m_ready.
module pool_out_serializer
  import pool_pkg::*;
#(
  parameter int ELEM_WIDTH         = POOL_ELEM_WIDTH,
  parameter int MAX_OUT_HEIGHT     = POOL_MAX_OUT_HEIGHT,
  parameter int MAX_OUT_WIDTH      = POOL_MAX_OUT_WIDTH,
  parameter int MAX_OUT_DATA_WIDTH = MAX_OUT_HEIGHT * MAX_OUT_WIDTH * ELEM_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic [MAX_OUT_DATA_WIDTH-1:0] data_in,
  input  logic [7:0]                    out_height,
  input  logic [7:0]                    out_width,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ELEM_WIDTH-1:0]         m_data,
  output logic                          m_last_col,
  output logic                          m_last,
  output logic                          busy,
  output logic                          overflow,
  output logic                          cfg_err
);

  ser_state_e                    state;
  logic [MAX_OUT_DATA_WIDTH-1:0] frame_buf;
  frame_dims_t                   dims_q;
  frame_dims_t                   dims_in;

  logic        in_legal;
  logic        xfer;
  logic        end_of_frame;
  logic        accepting;
  logic        capture;
  logic        step;
  logic [7:0]  nxt_row;
  logic [7:0]  nxt_col;
  logic        nxt_last_col;
  logic        nxt_last;
  logic [15:0] nxt_idx;

  assign dims_in      = '{height: out_height, width: out_width};
  assign in_legal     = dims_legal(dims_in, MAX_OUT_HEIGHT, MAX_OUT_WIDTH);
  assign xfer         = m_valid && m_ready;
  assign end_of_frame = xfer && m_last;
  // A new frame is only taken when idle or exactly on the final beat's transfer.
  assign accepting    = (state == SER_IDLE) || end_of_frame;
  assign capture      = valid_in && in_legal && accepting;
  assign step         = xfer && !m_last;
  assign nxt_idx      = ({8'd0, nxt_row} * {8'd0, dims_q.width}) + {8'd0, nxt_col};
  assign busy         = (state == SER_STREAM);

  stream_counter_2d u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (capture),
    .step         (step),
    .height       (dims_q.height),
    .width        (dims_q.width),
    .nxt_row      (nxt_row),
    .nxt_col      (nxt_col),
    .nxt_last_col (nxt_last_col),
    .nxt_last     (nxt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_buf <= '0;
      dims_q    <= '0;
    end else if (capture) begin
      frame_buf <= data_in;
      dims_q    <= dims_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SER_IDLE;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last_col <= 1'b0;
      m_last     <= 1'b0;
      overflow   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (valid_in && !in_legal && accepting) cfg_err <= 1'b1;
      if (valid_in && !accepting) overflow <= 1'b1;

      if (capture) begin
        state      <= SER_STREAM;
        m_valid    <= 1'b1;
        m_data     <= data_in[ELEM_WIDTH-1:0];
        m_last_col <= (out_width == 8'd1);
        m_last     <= (out_width == 8'd1) && (out_height == 8'd1);
      end else if (end_of_frame) begin
        state      <= SER_IDLE;
        m_valid    <= 1'b0;
        m_data     <= '0;
        m_last_col <= 1'b0;
        m_last     <= 1'b0;
      end else if (step) begin
        m_data     <= frame_buf[nxt_idx*ELEM_WIDTH +: ELEM_WIDTH];
        m_last_col <= nxt_last_col;
        m_last     <= nxt_last;
      end
    end
  end

endmodule
